// File: rtl/fwd_hazard_scoreboard_pkg.sv
// Shared forward-select codes and sizing helper for the forwarding/hazard unit.
// Code 0 means no bypass; code k selects producer stage k (1 = MEM, 2 = WB).
package fwd_hazard_scoreboard_pkg;

  localparam int FWD_SEL_NONE = 0;
  localparam int FWD_EX_MEM   = 1;
  localparam int FWD_MEM_WB   = 2;

  function automatic int fwd_sel_w(input int num_stg);
    return $clog2(num_stg + 1);
  endfunction

endpackage

// File: rtl/fwd_hazard_scoreboard_src_select.sv
// Bypass select for one EX source operand: the nearest producer stage that
// writes a non-zero register matching the source wins.
module fwd_src_select
  import fwd_hazard_scoreboard_pkg::*;
#(
  parameter int NUM_FWD_STG = 2,
  parameter int REG_AW      = 5,
  parameter int SEL_W       = 2
) (
  input  logic [REG_AW-1:0]             rs,
  input  logic [NUM_FWD_STG*REG_AW-1:0] stg_rd,
  input  logic [NUM_FWD_STG-1:0]        stg_reg_write,
  output logic [SEL_W-1:0]              sel
);

  // Scan farthest-to-nearest so the lowest matching stage overwrites last.
  always_comb begin
    sel = SEL_W'(FWD_SEL_NONE);
    for (int k = NUM_FWD_STG - 1; k >= 0; k--) begin
      if (stg_reg_write[k] &&
          (stg_rd[k*REG_AW +: REG_AW] != '0) &&
          (stg_rd[k*REG_AW +: REG_AW] == rs)) begin
        sel = SEL_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding selects, load-use detection and long-latency write scoreboard.
// Define FWD_PERF_CNT_EN to build the 32-bit stall-cycle counter.
module fwd_hazard_scoreboard
  import fwd_hazard_scoreboard_pkg::*;
#(
  parameter int NUM_SRC     = 2,
  parameter int NUM_FWD_STG = 2,
  parameter int REG_AW      = 5,
  parameter int MAX_OUTST   = 4,
  parameter int SEL_W       = fwd_sel_w(NUM_FWD_STG)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC*REG_AW-1:0]     ex_rs,
  input  logic [NUM_FWD_STG*REG_AW-1:0] stg_rd,
  input  logic [NUM_FWD_STG-1:0]        stg_reg_write,
  input  logic [NUM_SRC*REG_AW-1:0]     id_rs,
  input  logic [NUM_SRC-1:0]            id_rs_used,
  input  logic                          ex_mem_read,
  input  logic [REG_AW-1:0]             ex_rd,
  input  logic                          lu_issue_valid,
  input  logic [REG_AW-1:0]             lu_issue_rd,
  output logic                          lu_issue_ready,
  input  logic                          lu_done_valid,
  input  logic [REG_AW-1:0]             lu_done_rd,
  output logic [NUM_SRC*SEL_W-1:0]      forward_sel,
  output logic                          stall,
  output logic [(2**REG_AW)-1:0]        sb_busy,
  output logic [31:0]                   stall_cnt
);

  localparam int NUM_REGS = 2 ** REG_AW;
  localparam int CNT_W    = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    outst_cnt_q, outst_cnt_d;
  logic                load_use, sb_hit;
  logic                issue_set, done_clr;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_select #(
      .NUM_FWD_STG (NUM_FWD_STG),
      .REG_AW      (REG_AW),
      .SEL_W       (SEL_W)
    ) u_sel (
      .rs            (ex_rs[i*REG_AW +: REG_AW]),
      .stg_rd        (stg_rd),
      .stg_reg_write (stg_reg_write),
      .sel           (forward_sel[i*SEL_W +: SEL_W])
    );
  end

  always_comb begin
    load_use = 1'b0;
    sb_hit   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ex_mem_read && (ex_rd != '0) && id_rs_used[i] &&
          (id_rs[i*REG_AW +: REG_AW] == ex_rd)) begin
        load_use = 1'b1;
      end
      if (id_rs_used[i] && (id_rs[i*REG_AW +: REG_AW] != '0) &&
          busy_q[id_rs[i*REG_AW +: REG_AW]]) begin
        sb_hit = 1'b1;
      end
    end
  end

  // Handshake: an issue is accepted on a cycle where lu_issue_valid and
  // lu_issue_ready are both high; valid held without ready stalls ID and retries.
  assign lu_issue_ready = ~rst & (outst_cnt_q < MAX_CNT) & ~busy_q[lu_issue_rd] &
                          ~load_use & ~sb_hit;
  assign stall          = ~rst & (load_use | sb_hit | (lu_issue_valid & ~lu_issue_ready));

  // x0 never gets an entry, so a done on x0 finds it clear and is dropped.
  assign issue_set = lu_issue_valid & lu_issue_ready & (lu_issue_rd != '0);
  assign done_clr  = lu_done_valid & busy_q[lu_done_rd];

  always_comb begin
    busy_d      = busy_q;
    outst_cnt_d = outst_cnt_q;
    if (done_clr) begin
      busy_d[lu_done_rd] = 1'b0;
      outst_cnt_d        = outst_cnt_d - CNT_W'(1);
    end
    if (issue_set) begin
      busy_d[lu_issue_rd] = 1'b1;
      outst_cnt_d         = outst_cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      outst_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      outst_cnt_q <= outst_cnt_d;
    end
  end

  assign sb_busy = busy_q;

`ifdef FWD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= 32'd0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Bench for fwd_hazard_scoreboard: directed literal scenarios followed by
// randomized traffic, all checked every cycle against a behavioural model.
module tb_fwd_hazard_scoreboard;

  localparam int NUM_SRC     = 2;
  localparam int NUM_FWD_STG = 2;
  localparam int REG_AW      = 5;
  localparam int MAX_OUTST   = 4;
  localparam int SEL_W       = 2;
  localparam int NUM_REGS    = 32;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [NUM_SRC*REG_AW-1:0]     ex_rs;
  logic [NUM_FWD_STG*REG_AW-1:0] stg_rd;
  logic [NUM_FWD_STG-1:0]        stg_reg_write;
  logic [NUM_SRC*REG_AW-1:0]     id_rs;
  logic [NUM_SRC-1:0]            id_rs_used;
  logic                          ex_mem_read;
  logic [REG_AW-1:0]             ex_rd;
  logic                          lu_issue_valid;
  logic [REG_AW-1:0]             lu_issue_rd;
  logic                          lu_issue_ready;
  logic                          lu_done_valid;
  logic [REG_AW-1:0]             lu_done_rd;
  logic [NUM_SRC*SEL_W-1:0]      forward_sel;
  logic                          stall;
  logic [NUM_REGS-1:0]           sb_busy;
  logic [31:0]                   stall_cnt;

  int checks = 0;
  int errors = 0;

  fwd_hazard_scoreboard #(
    .NUM_SRC     (NUM_SRC),
    .NUM_FWD_STG (NUM_FWD_STG),
    .REG_AW      (REG_AW),
    .MAX_OUTST   (MAX_OUTST)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_rs          (ex_rs),
    .stg_rd         (stg_rd),
    .stg_reg_write  (stg_reg_write),
    .id_rs          (id_rs),
    .id_rs_used     (id_rs_used),
    .ex_mem_read    (ex_mem_read),
    .ex_rd          (ex_rd),
    .lu_issue_valid (lu_issue_valid),
    .lu_issue_rd    (lu_issue_rd),
    .lu_issue_ready (lu_issue_ready),
    .lu_done_valid  (lu_done_valid),
    .lu_done_rd     (lu_done_rd),
    .forward_sel    (forward_sel),
    .stall          (stall),
    .sb_busy        (sb_busy),
    .stall_cnt      (stall_cnt)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // behavioural model state
  bit [NUM_REGS-1:0] m_busy = '0;
  int                m_cnt  = 0;
  bit [31:0]         m_scnt = 0;
  bit                chk_en = 1'b0;
  bit                m_acc, m_dn;

  function automatic logic [REG_AW-1:0] src_of(input logic [NUM_SRC*REG_AW-1:0] v, input int i);
    return v[i*REG_AW +: REG_AW];
  endfunction

  function automatic int m_fwd(input int i);
    for (int k = 0; k < NUM_FWD_STG; k++) begin
      if (stg_reg_write[k] && stg_rd[k*REG_AW +: REG_AW] != 0 &&
          stg_rd[k*REG_AW +: REG_AW] == src_of(ex_rs, i))
        return k + 1;
    end
    return 0;
  endfunction

  function automatic bit m_load_use();
    if (!ex_mem_read || ex_rd == 0) return 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      if (id_rs_used[i] && src_of(id_rs, i) == ex_rd) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_sb_hit();
    for (int i = 0; i < NUM_SRC; i++)
      if (id_rs_used[i] && src_of(id_rs, i) != 0 && m_busy[src_of(id_rs, i)]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ready();
    return !rst && (m_cnt < MAX_OUTST) && !m_busy[lu_issue_rd] && !m_load_use() && !m_sb_hit();
  endfunction

  function automatic bit m_stall();
    return !rst && (m_load_use() || m_sb_hit() || (lu_issue_valid && !m_ready()));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model update on every active edge, using the inputs that edge sees
  always @(posedge clk) begin
    if (rst) begin
      m_busy = '0;
      m_cnt  = 0;
      m_scnt = 0;
      chk_en = 1'b1;
    end else begin
      m_acc = lu_issue_valid && m_ready();
      m_dn  = lu_done_valid && m_busy[lu_done_rd];
      if (m_stall()) m_scnt = m_scnt + 1;
      if (m_dn) begin
        m_busy[lu_done_rd] = 1'b0;
        m_cnt--;
      end
      if (m_acc && lu_issue_rd != 0) begin
        m_busy[lu_issue_rd] = 1'b1;
        m_cnt++;
      end
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NUM_SRC; i++)
        chk($sformatf("forward_sel[%0d]", i), 32'(forward_sel[i*SEL_W +: SEL_W]), 32'(m_fwd(i)));
      chk("stall", 32'(stall), 32'(m_stall()));
      chk("lu_issue_ready", 32'(lu_issue_ready), 32'(m_ready()));
      chk("sb_busy", sb_busy, m_busy);
`ifdef FWD_PERF_CNT_EN
      chk("stall_cnt", stall_cnt, m_scnt);
`else
      chk("stall_cnt", stall_cnt, 32'd0);
`endif
    end
  end

  // driver tasks
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_rs = '0; stg_rd = '0; stg_reg_write = '0;
    id_rs = '0; id_rs_used = '0; ex_mem_read = 1'b0; ex_rd = '0;
    lu_issue_valid = 1'b0; lu_issue_rd = '0;
    lu_done_valid = 1'b0; lu_done_rd = '0;
  endtask

  task automatic randomize_inputs();
    rst            = ($urandom_range(0, 99) == 0);
    for (int i = 0; i < NUM_SRC; i++) begin
      ex_rs[i*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
      id_rs[i*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
    end
    for (int k = 0; k < NUM_FWD_STG; k++)
      stg_rd[k*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
    stg_reg_write  = NUM_FWD_STG'($urandom_range(0, 3));
    id_rs_used     = NUM_SRC'($urandom_range(0, 3));
    ex_mem_read    = ($urandom_range(0, 3) == 0);
    ex_rd          = REG_AW'($urandom_range(0, 7));
    lu_issue_valid = ($urandom_range(0, 1) == 1);
    lu_issue_rd    = REG_AW'($urandom_range(0, 7));
    lu_done_valid  = ($urandom_range(0, 1) == 1);
    lu_done_rd     = REG_AW'($urandom_range(0, 7));
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset sb_busy", sb_busy, 32'h0);
    chk("reset stall_cnt", stall_cnt, 32'h0);

    // forwarding priority
    next(); idle();
    stg_rd = {5'd5, 5'd5}; stg_reg_write = 2'b11; ex_rs[4:0] = 5'd5;
    @(negedge clk); chk("t1 both stages", 32'(forward_sel[1:0]), 32'd1);
    next(); stg_reg_write = 2'b10;
    @(negedge clk); chk("t1 wb only", 32'(forward_sel[1:0]), 32'd2);
    next(); stg_reg_write = 2'b11; stg_rd = '0; ex_rs = '0;
    @(negedge clk); chk("t1 x0", 32'(forward_sel[1:0]), 32'd0);

    // load-use
    next(); idle();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs[9:5] = 5'd7; id_rs_used = 2'b10;
    lu_issue_valid = 1'b1; lu_issue_rd = 5'd10;
    @(negedge clk); chk("t2 stall", 32'(stall), 32'd1); chk("t2 ready", 32'(lu_issue_ready), 32'd0);
    next(); lu_issue_valid = 1'b0; id_rs_used = 2'b00;
    @(negedge clk); chk("t2 unused", 32'(stall), 32'd0);

    // scoreboard hit until done
    next(); idle(); lu_issue_valid = 1'b1; lu_issue_rd = 5'd9;
    @(negedge clk); chk("t3 issue ready", 32'(lu_issue_ready), 32'd1);
    next(); lu_issue_valid = 1'b0; id_rs[4:0] = 5'd9; id_rs_used = 2'b01;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); chk("t3 sb stall", 32'(stall), 32'd1);
      next();
    end
    lu_done_valid = 1'b1; lu_done_rd = 5'd9;
    @(negedge clk); chk("t3 done cycle stall", 32'(stall), 32'd1);
    next(); lu_done_valid = 1'b0;
    @(negedge clk); chk("t3 after done", 32'(stall), 32'd0);

    // fill to MAX_OUTST
    next(); idle();
    for (int r = 1; r <= 4; r++) begin
      lu_issue_valid = 1'b1; lu_issue_rd = REG_AW'(r);
      @(negedge clk); chk("t4 fill ready", 32'(lu_issue_ready), 32'd1);
      next();
    end
    lu_issue_rd = 5'd5;
    @(negedge clk); chk("t4 full ready", 32'(lu_issue_ready), 32'd0);
    chk("t4 full stall", 32'(stall), 32'd1); chk("t4 busy", sb_busy, 32'h1E);
    next(); lu_done_valid = 1'b1; lu_done_rd = 5'd2;
    @(negedge clk); chk("t4 done+issue ready", 32'(lu_issue_ready), 32'd0);
    next(); lu_done_valid = 1'b0;
    @(negedge clk); chk("t4 retry ready", 32'(lu_issue_ready), 32'd1); chk("t4 busy2", sb_busy, 32'h1A);
    next(); lu_issue_valid = 1'b0;
    @(negedge clk); chk("t4 busy3", sb_busy, 32'h3A);

    // WAW block, same-cycle done+issue, spurious done, x0 issue
    next(); lu_done_valid = 1'b1; lu_done_rd = 5'd1;
    next(); lu_done_valid = 1'b0; lu_issue_valid = 1'b1; lu_issue_rd = 5'd3;
    @(negedge clk); chk("t5 waw ready", 32'(lu_issue_ready), 32'd0); chk("t5 busy", sb_busy, 32'h38);
    next(); lu_done_valid = 1'b1; lu_done_rd = 5'd4; lu_issue_rd = 5'd7;
    @(negedge clk); chk("t5 swap ready", 32'(lu_issue_ready), 32'd1);
    next(); lu_done_rd = 5'd8; lu_issue_valid = 1'b0;
    @(negedge clk); chk("t5 swap busy", sb_busy, 32'hA8);
    next(); lu_done_valid = 1'b0; lu_issue_valid = 1'b1; lu_issue_rd = 5'd0;
    @(negedge clk); chk("t5 x0 ready", 32'(lu_issue_ready), 32'd1); chk("t5 spurious done", sb_busy, 32'hA8);
    next(); lu_issue_valid = 1'b0;
    @(negedge clk); chk("t5 x0 no entry", sb_busy, 32'hA8);

    // reset with entries pending, then stall counting
    next(); rst = 1'b1; lu_issue_valid = 1'b1; lu_issue_rd = 5'd10;
    @(negedge clk); chk("t6 rst stall", 32'(stall), 32'd0); chk("t6 rst ready", 32'(lu_issue_ready), 32'd0);
    next(); rst = 1'b0; lu_issue_valid = 1'b0; lu_done_valid = 1'b1; lu_done_rd = 5'd5;
    @(negedge clk); chk("t6 busy clr", sb_busy, 32'h0); chk("t6 cnt clr", stall_cnt, 32'd0);
    next(); idle();
    @(negedge clk); chk("t6 late done", sb_busy, 32'h0);
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs[4:0] = 5'd7; id_rs_used = 2'b01;
    repeat (5) next();
    idle();
    @(negedge clk);
`ifdef FWD_PERF_CNT_EN
    chk("t6 stall_cnt", stall_cnt, 32'd5);
`else
    chk("t6 stall_cnt", stall_cnt, 32'd0);
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      next();
      randomize_inputs();
    end
    next(); idle(); rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
